// File: rtl/sdram_host_port.sv
// Host-side request sequencer for the SDRAM controller: queues host requests and
// presents them one at a time on the controller's request pins until accepted.
module sdram_host_port #(
    parameter int HADDR_WIDTH    = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int ACCEPT_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]            req_wdata,
    output logic                   resp_valid,
    output logic [15:0]            resp_rdata,
    output logic                   wr_done,
    output logic                   err,
    output logic [HADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]            wr_data,
    output logic                   wr_enable,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_enable,
    input  logic [15:0]            rd_data,
    input  logic                   rd_ready,
    input  logic                   busy
);
    // state | meaning
    // IDLE  | nothing outstanding; pop the head once busy is low
    // ISSUE | enable held until the controller raises busy
    // WAIT  | accepted; read waits for rd_ready, write waits for busy low
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(ACCEPT_TIMEOUT + 1);

    state_t                 state;
    logic [FIFO_DEPTH-1:0]  fifo_we;
    logic [HADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [15:0]            fifo_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   cur_we;
    logic                   push;
    logic                   pop;

    assign req_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0) && !busy;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= req_we;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tmo_cnt    <= '0;
            cur_we     <= 1'b0;
            wr_enable  <= 1'b0;
            rd_enable  <= 1'b0;
            resp_valid <= 1'b0;
            wr_done    <= 1'b0;
            err        <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_data    <= '0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            wr_done    <= 1'b0;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);

            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_we  <= fifo_we[rd_ptr];
                        tmo_cnt <= TMO_W'(ACCEPT_TIMEOUT);
                        if (fifo_we[rd_ptr]) begin
                            wr_addr   <= fifo_addr[rd_ptr];
                            wr_data   <= fifo_wdata[rd_ptr];
                            wr_enable <= 1'b1;
                        end else begin
                            rd_addr   <= fifo_addr[rd_ptr];
                            rd_enable <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (busy) begin
                        wr_enable <= 1'b0;
                        rd_enable <= 1'b0;
                        tmo_cnt   <= TMO_W'(ACCEPT_TIMEOUT);
                        state     <= WAIT;
                    end else if (tmo_cnt != '0) begin
                        // Timeout only flags the stall; the request keeps being offered.
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                        if (tmo_cnt == TMO_W'(1)) err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cur_we) begin
                        if (!busy) begin
                            wr_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (rd_ready) begin
                        resp_rdata <= rd_data;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_host_port.sv
// Bench for sdram_host_port: a behavioural controller/SDRAM stub answers the request
// pins while a queue of pushed requests and a memory map predict every completion.
module tb_sdram_host_port;
    localparam int AW    = 24;
    localparam int DEPTH = 4;
    localparam int TMO   = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic          req_ready, resp_valid, wr_done, err, wr_enable, rd_enable;
    logic [15:0]   resp_rdata, wr_data;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [15:0]   rd_data = '0;
    logic          rd_ready = 1'b0;
    logic          busy = 1'b0;

    always #5 clk = ~clk;

    sdram_host_port #(.HADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .ACCEPT_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wr_done(wr_done), .err(err),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .rd_addr(rd_addr), .rd_enable(rd_enable),
        .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller + SDRAM stub: refuses requests during init/refresh/deaf windows,
    // then busy for a random latency plus one stale cycle.
    int cyc = 0;
    int hold_until = 0;
    int ref_until = 0;
    int fixed_lat = 0;
    bit deaf = 1'b0;
    bit busy_hold = 1'b0;
    int ph = 0;
    int lat = 0;
    logic          op_we = 1'b0;
    logic [AW-1:0] op_addr = '0;
    logic [15:0]   op_data = '0;
    bit [15:0]     mem [bit [AW-1:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_ready <= 1'b0;
        if (rst) begin
            ph   <= 0;
            busy <= 1'b0;
        end else if (ph == 0) begin
            if (cyc >= hold_until && cyc % 97 == 60) ref_until <= cyc + 8;
            if (deaf || busy_hold || cyc < hold_until || cyc < ref_until) begin
                busy <= busy_hold;
            end else if (wr_enable || rd_enable) begin
                op_we   <= wr_enable;
                op_addr <= wr_enable ? wr_addr : rd_addr;
                op_data <= wr_data;
                lat     <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
                busy    <= 1'b1;
                ph      <= 1;
            end else begin
                busy <= 1'b0;
            end
        end else if (ph == 1) begin
            if (lat > 1) begin
                lat <= lat - 1;
            end else begin
                if (op_we) begin
                    mem[op_addr] = op_data;
                end else begin
                    rd_data  <= mem.exists(op_addr) ? mem[op_addr] : 16'h0000;
                    rd_ready <= 1'b1;
                end
                ph <= 2;
            end
        end else begin
            busy <= 1'b0;
            ph   <= 0;
        end
    end

    // Reference: requests complete in push order; reads return the last write in that order.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
    } req_t;

    req_t          exp_q[$];
    bit [15:0]     ref_mem [bit [AW-1:0]];
    int            n_push = 0;
    int            n_pop = 0;
    int            n_cmp = 0;
    int            n_en = 0;
    logic          prev_wen = 1'b0;
    logic          prev_ren = 1'b0;
    logic [AW-1:0] prev_waddr = '0;
    logic [AW-1:0] prev_raddr = '0;
    logic [15:0]   prev_wdata = '0;
    logic [15:0]   last_rdata = '0;

    always @(negedge clk) begin
        req_t e;
        if (rst) begin
            exp_q.delete();
            n_push   = 0;
            n_pop    = 0;
            prev_wen = 1'b0;
            prev_ren = 1'b0;
        end else begin
            chk("en_overlap", 64'(wr_enable & rd_enable), 64'(0));
            if (wr_enable || rd_enable) n_en++;
            if (wr_enable && prev_wen)
                chk("wr_hold", 64'({wr_addr, wr_data}), 64'({prev_waddr, prev_wdata}));
            if (rd_enable && prev_ren)
                chk("rd_hold", 64'(rd_addr), 64'(prev_raddr));
            if ((wr_enable && !prev_wen) || (rd_enable && !prev_ren)) begin
                n_pop++;
                chk("issue_pending", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("issue_we", 64'(wr_enable), 64'(e.we));
                    chk("issue_addr", 64'(e.we ? wr_addr : rd_addr), 64'(e.addr));
                    if (e.we) chk("issue_wdata", 64'(wr_data), 64'(e.wdata));
                end
            end
            if (resp_valid === 1'b1 || wr_done === 1'b1) begin
                chk("resp_single", 64'(resp_valid & wr_done), 64'(0));
                chk("resp_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    chk("resp_kind", 64'(wr_done), 64'(e.we));
                    if (e.we) begin
                        ref_mem[e.addr] = e.wdata;
                    end else begin
                        chk("rdata", 64'(resp_rdata),
                            64'(ref_mem.exists(e.addr) ? ref_mem[e.addr] : 16'h0000));
                        last_rdata = resp_rdata;
                    end
                end
            end
            chk("req_ready", 64'(req_ready), 64'((n_push - n_pop) != DEPTH));
            if (req_valid && req_ready) begin
                e.we    = req_we;
                e.addr  = req_addr;
                e.wdata = req_wdata;
                exp_q.push_back(e);
                n_push++;
            end
        end
        prev_wen   = wr_enable;
        prev_ren   = rd_enable;
        prev_waddr = wr_addr;
        prev_raddr = rd_addr;
        prev_wdata = wr_data;
    end

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [15:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 64'(n < 2000), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        #1;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int d0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        hold_until = cyc + 30;

        @(negedge clk);
        chk("rst_enables", 64'({wr_enable, rd_enable, resp_valid, wr_done, err}), 64'(0));
        chk("rst_addrs", 64'({wr_addr, rd_addr}), 64'(0));
        chk("rst_data", 64'({wr_data, resp_rdata}), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;

        // Write issued during controller init
        d0 = n_cmp;
        n  = n_en;
        push(1'b1, 24'h012345, 16'hBEEF);
        drain();
        chk("init_done_count", 64'(n_cmp - d0), 64'(1));
        chk("init_hold_len", 64'((n_en - n) >= 25), 64'(1));
        chk("init_err", 64'(err), 64'(0));

        // Write then read back-to-back
        push(1'b1, 24'h000010, 16'hA5A5);
        push(1'b0, 24'h000010, 16'h0000);
        drain();
        chk("wr_rd_data", 64'(last_rdata), 64'(16'hA5A5));

        // Fill the FIFO while the controller looks busy
        busy_hold = 1'b1;
        d0 = n_cmp;
        for (int i = 0; i < 4; i++) push(1'($urandom), AW'(24'h100 + i), 16'($urandom));
        @(negedge clk);
        chk("full_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        busy_hold = 1'b0;
        push(1'b0, 24'h000101, 16'h0000);
        drain();
        chk("full_all_done", 64'(n_cmp - d0), 64'(5));

        // Random traffic over a small address window, with periodic refresh
        d0 = n_cmp;
        for (int i = 0; i < 60; i++) begin
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            push(1'($urandom), AW'(24'h100 + $urandom_range(0, 7)), 16'($urandom));
        end
        drain();
        chk("rand_all_done", 64'(n_cmp - d0), 64'(60));
        chk("rand_err", 64'(err), 64'(0));

        // Acceptance timeout
        deaf = 1'b1;
        push(1'b1, 24'h000ABC, 16'h1234);
        n = 0;
        @(negedge clk);
        while (wr_enable !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_issue", 64'(wr_enable), 64'(1));
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_err_before", 64'(err), 64'(0));
        @(negedge clk);
        chk("tmo_err_set", 64'(err), 64'(1));
        chk("tmo_en_held", 64'(wr_enable), 64'(1));
        @(posedge clk);
        #1;
        deaf = 1'b0;
        drain();
        chk("tmo_err_sticky", 64'(err), 64'(1));

        // Reset while a read waits with two more queued
        fixed_lat = 30;
        push(1'b0, 24'h000010, 16'h0000);
        push(1'b0, 24'h000011, 16'h0000);
        push(1'b0, 24'h000012, 16'h0000);
        n = 0;
        @(negedge clk);
        while (!(busy === 1'b1 && rd_enable === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rw_wait_reached", 64'(n < 100), 64'(1));
        chk("rw_queued", 64'(n_push - n_pop), 64'(2));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fixed_lat = 0;
        @(negedge clk);
        chk("rw_enables", 64'({wr_enable, rd_enable}), 64'(0));
        chk("rw_ready", 64'(req_ready), 64'(1));
        chk("rw_err_clr", 64'(err), 64'(0));
        n  = 0;
        d0 = n_en;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid === 1'b1) n++;
        end
        chk("rw_no_resp", 64'(n), 64'(0));
        chk("rw_no_issue", 64'(n_en - d0), 64'(0));
        @(posedge clk);
        #1;

        push(1'b0, 24'h012345, 16'h0000);
        drain();
        chk("post_rst_read", 64'(last_rdata), 64'(16'hBEEF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
